// File: rtl/matmul_arbiter_if.sv
// Bus bundle between client requesters, the arbiter and the shared
// 3x3 matmul engine. Arbiter side is the slave modport.
interface matmul_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ELEM_W = 7
);
    localparam int MW = 9 * ELEM_W;

    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*MW-1:0] i_a;
    logic [N_REQ*MW-1:0] i_b;
    logic [N_REQ-1:0]    o_gnt;
    logic [N_REQ-1:0]    o_done;
    logic [MW-1:0]       o_result;
    logic                o_busy;
    logic [MW-1:0]       o_mm_a;
    logic [MW-1:0]       o_mm_b;
    logic                o_mm_trigger;
    logic                i_mm_ready;
    logic [MW-1:0]       i_mm_result;

    modport slave (
        input  i_req, i_a, i_b, i_mm_ready, i_mm_result,
        output o_gnt, o_done, o_result, o_busy,
        output o_mm_a, o_mm_b, o_mm_trigger
    );

    modport master (
        output i_req, i_a, i_b, i_mm_ready, i_mm_result,
        input  o_gnt, o_done, o_result, o_busy,
        input  o_mm_a, o_mm_b, o_mm_trigger
    );
endinterface

// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one 3x3 matmul engine between N_REQ
// requesters: grant, latch operands, trigger, wait LAT, return result.
module matmul_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ELEM_W = 7,
    parameter int LAT    = 2
) (
    input logic              i_clk,
    input logic              i_rst,
    matmul_arbiter_if.slave  bus
);
    localparam int MW = 9 * ELEM_W;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [MW-1:0]  result_q, result_d;
    logic [MW-1:0]  mm_a_q, mm_a_d;
    logic [MW-1:0]  mm_b_q, mm_b_d;

    logic           win_vld;
    logic [IW-1:0]  win_idx;
    logic [IW-1:0]  probe;

    // Rotating search for the first request after the last owner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        probe   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            probe = IW'((int'(last_q) + i) % N_REQ);
            if (!win_vld && bus.i_req[probe]) begin
                win_vld = 1'b1;
                win_idx = probe;
            end
        end
    end

    // Next-state logic: arbitrate, issue to the engine, wait, capture.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        done_d   = '0;
        result_d = result_q;
        mm_a_d   = mm_a_q;
        mm_b_d   = mm_b_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    idx_d          = win_idx;
                    gnt_d[win_idx] = 1'b1;
                    mm_a_d  = bus.i_a[int'(win_idx)*MW +: MW];
                    mm_b_d  = bus.i_b[int'(win_idx)*MW +: MW];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.i_mm_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LAT - 1)) begin
                    result_d      = bus.i_mm_result;
                    done_d[idx_q] = 1'b1;
                    last_d        = idx_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            last_q   <= IW'(N_REQ - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
        end
    end

    assign bus.o_gnt        = gnt_q;
    assign bus.o_done       = done_q;
    assign bus.o_result     = result_q;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_mm_a       = mm_a_q;
    assign bus.o_mm_b       = mm_b_q;
    assign bus.o_mm_trigger = (state_q == ISSUE) && bus.i_mm_ready;
endmodule

// File: tb/tb_matmul_arbiter.sv
// Randomized bench for matmul_arbiter with a transaction-level model
// and a behavioural engine that only shows its result in the valid cycle.
module tb_matmul_arbiter;
    localparam int N   = 4;
    localparam int W   = 7;
    localparam int LAT = 2;
    localparam int MW  = 9 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_arbiter_if #(.N_REQ(N), .ELEM_W(W)) bus ();

    matmul_arbiter #(.N_REQ(N), .ELEM_W(W), .LAT(LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    int          m_owner;
    int          m_last;
    int          m_we;
    bit          m_acc;
    logic [N-1:0]  m_gnt;
    logic [N-1:0]  m_done;
    logic [MW-1:0] m_a, m_b, m_res;

    int          eng_e;
    logic [MW-1:0] eng_p, eng_n;
    bit          trig_seen;
    int          gq[$];

    task automatic chk(input string n, input logic [255:0] act,
                       input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] mm(input logic [MW-1:0] a,
                                         input logic [MW-1:0] b);
        logic [MW-1:0] c;
        int s;
        c = '0;
        for (int r = 0; r < 3; r++)
            for (int col = 0; col < 3; col++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(a[(r*3+k)*W +: W]) * int'(b[(k*3+col)*W +: W]);
                c[(r*3+col)*W +: W] = W'(s);
            end
        return c;
    endfunction

    function automatic logic [MW-1:0] fill(input int v);
        logic [MW-1:0] c;
        for (int e = 0; e < 9; e++) c[e*W +: W] = W'(v);
        return c;
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        logic [MW-1:0] c;
        for (int e = 0; e < 9; e++) c[e*W +: W] = W'($urandom);
        return c;
    endfunction

    function automatic int pick(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++)
            if (req[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_acc   = 0;
        m_we    = 0;
        m_gnt   = '0;
        m_done  = '0;
        m_a     = '0;
        m_b     = '0;
        m_res   = '0;
        eng_e   = -1;
    endtask

    task automatic model_step();
        m_gnt  = '0;
        m_done = '0;
        if (rst) begin
            model_reset();
            return;
        end
        if (trig_seen) begin
            eng_e = 0;
            eng_p = eng_n;
        end else if (eng_e >= 0) begin
            eng_e++;
            if (eng_e >= LAT) eng_e = -1;
        end
        if (m_owner < 0) begin
            if (bus.i_req != '0) begin
                m_owner = pick(bus.i_req, m_last);
                m_gnt[m_owner] = 1'b1;
                m_a   = bus.i_a[m_owner*MW +: MW];
                m_b   = bus.i_b[m_owner*MW +: MW];
                m_acc = 0;
            end
        end else if (!m_acc) begin
            if (bus.i_mm_ready) begin
                m_acc = 1;
                m_we  = 0;
            end
        end else begin
            m_we++;
            if (m_we == LAT) begin
                m_res = mm(m_a, m_b);
                m_done[m_owner] = 1'b1;
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic compare_all();
        chk("gnt", bus.o_gnt, m_gnt);
        chk("done", bus.o_done, m_done);
        chk("result", bus.o_result, m_res);
        chk("busy", bus.o_busy, m_owner >= 0);
        chk("mm_a", bus.o_mm_a, m_a);
        chk("mm_b", bus.o_mm_b, m_b);
        if (bus.o_gnt != '0) gq.push_back($clog2(bus.o_gnt));
    endtask

    // One clock: trigger check before the edge, model at the edge,
    // engine drive on the falling edge, full compare just after it.
    task automatic cycle();
        #1;
        chk("trigger", bus.o_mm_trigger,
            m_owner >= 0 && !m_acc && bus.i_mm_ready && !rst);
        trig_seen = bus.o_mm_trigger;
        eng_n = mm(bus.o_mm_a, bus.o_mm_b);
        @(posedge clk);
        model_step();
        @(negedge clk);
        bus.i_mm_result = (eng_e == LAT - 1) ? eng_p : rnd_mat();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_gnt", bus.o_gnt, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_result", bus.o_result, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_mm_a", bus.o_mm_a, 0);
        chk("rst_mm_b", bus.o_mm_b, 0);
        chk("rst_trigger", bus.o_mm_trigger, 0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (bus.o_done == '0 && n < max) begin
            cycle();
            n++;
        end
        if (bus.o_done == '0) chk("done_timeout", 1, 0);
    endtask

    task automatic drain();
        int n = 0;
        bus.i_req = '0;
        bus.i_mm_ready = 1'b1;
        while ((m_owner >= 0 || bus.o_busy) && n < 50) begin
            cycle();
            n++;
        end
        if (n >= 50) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        int n;
        logic [MW-1:0] ident, seq;
        rst = 1'b1;
        bus.i_req = '0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_mm_ready = 1'b1;
        bus.i_mm_result = '0;
        trig_seen = 0;
        model_reset();
        @(negedge clk);
        #1;
        apply_reset();

        // single request: identity * {1..9}
        ident = '0;
        seq = '0;
        for (int e = 0; e < 9; e++) seq[e*W +: W] = W'(e + 1);
        for (int r = 0; r < 3; r++) ident[(r*3+r)*W +: W] = W'(1);
        bus.i_a[0 +: MW] = ident;
        bus.i_b[0 +: MW] = seq;
        bus.i_req = 4'b0001;
        cycle();
        chk("single_gnt", bus.o_gnt, 4'b0001);
        bus.i_req = '0;
        wait_done(20, n);
        chk("single_lat", n, LAT + 1);
        chk("single_done", bus.o_done, 4'b0001);
        chk("single_res", bus.o_result, seq);
        drain();

        // round-robin with all requests held
        apply_reset();
        for (int k = 0; k < N; k++) begin
            bus.i_a[k*MW +: MW] = rnd_mat();
            bus.i_b[k*MW +: MW] = rnd_mat();
        end
        gq.delete();
        bus.i_req = 4'b1111;
        n = 0;
        while (gq.size() < 8 && n < 100) begin
            cycle();
            n++;
        end
        bus.i_req = '0;
        chk("rr_count", gq.size(), 8);
        for (int i = 0; i < 8 && i < gq.size(); i++)
            chk("rr_order", gq[i], i % 4);
        drain();

        // ready stall for five cycles
        bus.i_mm_ready = 1'b0;
        bus.i_req = 4'b0001;
        cycle();
        bus.i_req = '0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_busy", bus.o_busy, 1);
            chk("stall_trig", bus.o_mm_trigger, 0);
        end
        bus.i_mm_ready = 1'b1;
        cycle();
        wait_done(20, n);
        chk("stall_lat", n, LAT);
        drain();

        // operand isolation on requester 2
        bus.i_a[2*MW +: MW] = fill(2);
        bus.i_b[2*MW +: MW] = fill(3);
        bus.i_req = 4'b0100;
        cycle();
        chk("iso_gnt", bus.o_gnt, 4'b0100);
        bus.i_a[2*MW +: MW] = '0;
        bus.i_req = '0;
        wait_done(20, n);
        chk("iso_done", bus.o_done, 4'b0100);
        chk("iso_res", bus.o_result, fill(18));
        drain();

        // engine truncation is passed through unchanged
        bus.i_a[3*MW +: MW] = fill(10);
        bus.i_b[3*MW +: MW] = fill(10);
        bus.i_req = 4'b1000;
        cycle();
        bus.i_req = '0;
        wait_done(20, n);
        chk("trunc_done", bus.o_done, 4'b1000);
        chk("trunc_res", bus.o_result, fill(44));
        drain();

        // reset one cycle into WAIT
        bus.i_req = 4'b0001;
        cycle();
        bus.i_req = '0;
        cycle();
        cycle();
        chk("pre_rst_busy", bus.o_busy, 1);
        apply_reset();
        chk("post_rst_done", bus.o_done, 0);
        bus.i_req = 4'b1010;
        cycle();
        chk("post_rst_gnt", bus.o_gnt, 4'b0010);
        bus.i_req = '0;
        drain();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                bus.i_req = N'($urandom_range(0, 15));
            bus.i_mm_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                bus.i_a[k*MW +: MW] = rnd_mat();
                bus.i_b[k*MW +: MW] = rnd_mat();
            end
            if ($urandom_range(0, 499) == 0) apply_reset();
            else cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matmul_arbiter.md
Name: matmul_arbiter

Overview:
- Shares one 3x3 matrix-multiply engine between N_REQ requesters using round-robin arbitration.
- Latches the granted requester's operands and sequences the engine's trigger/ready handshake.
- Waits a fixed latency, captures the result and returns it with a one-cycle done pulse to the owner.
- Sits between client blocks and the single matmul engine instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ELEM_W, 7, element width in bits.
- LAT, 2, rising edges from the trigger-accept edge to a valid i_mm_result (>=1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_req  in  N_REQ  request per requester; level, held until granted.
- i_a  in  N_REQ*9*ELEM_W  per-requester A operand. Requester k uses slice k; element [r][c] is at offset (r*3+c)*ELEM_W within the slice.
- i_b  in  N_REQ*9*ELEM_W  per-requester B operand; same packing as i_a.
- o_gnt  out  N_REQ  one-hot, one-cycle grant; operands are sampled on this cycle.
- o_done  out  N_REQ  one-hot, one-cycle completion pulse to the owner.
- o_result  out  9*ELEM_W  product; valid on the o_done cycle and held until the next capture.
- o_busy  out  1  high in every state except IDLE.
- o_mm_a  out  9*ELEM_W  latched A to the engine.
- o_mm_b  out  9*ELEM_W  latched B to the engine.
- o_mm_trigger  out  1  engine start.
- i_mm_ready  in  1  engine ready.
- i_mm_result  in  9*ELEM_W  engine result.

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is asynchronous, active-high.
- Reset values:
  - o_gnt=0, o_done=0, o_result=0, o_mm_a=0, o_mm_b=0, o_mm_trigger=0, o_busy=0.
  - State IDLE; round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- IDLE:
  - If i_req!=0, select the first set bit searching last+1, last+2, ... with wrap modulo N_REQ.
  - On that edge: register idx, o_gnt[idx]=1 for the next cycle, and latch slice idx of i_a/i_b into o_mm_a/o_mm_b. Go to ISSUE.
  - If i_req==0, stay in IDLE.
- ISSUE:
  - o_mm_trigger is combinationally equal to i_mm_ready in this state; o_mm_trigger=0 in all other states.
  - On the edge where i_mm_ready=1: clear the counter and go to WAIT.
  - Otherwise remain in ISSUE indefinitely, with no timeout.
- WAIT:
  - Counter increments every edge.
  - On the edge where the counter reaches LAT-1: o_result<=i_mm_result, o_done[idx]=1 for the next cycle, last<=idx. Go to IDLE.
- Latency:
  - Grant is seen 1 cycle after the request wins arbitration.
  - Done is seen LAT cycles after the trigger-accept edge.
  - With i_mm_ready constantly high: request seen at edge 0 -> grant visible cycle 1 -> trigger accepted edge 1 -> o_done visible cycle 1+LAT.
- Back-to-back operation:
  - The IDLE state on the done cycle may arbitrate again.
  - A new o_gnt may appear in the cycle right after o_done.
- o_gnt and o_done are never both set on the same bit in the same cycle.
- Request handling:
  - Requests are sampled only in IDLE.
  - A requester that deasserts i_req before being granted is not served.
  - A requester still holding i_req after its o_done is a new request, at lowest priority relative to the others.
- Operand stability: operands are sampled only on the grant cycle; later changes on i_a/i_b have no effect on the operation in flight.
- Arithmetic: no arithmetic in this block. o_result is a bit-exact copy of i_mm_result, including engine truncation to ELEM_W bits.
- Reset mid-operation: aborts immediately. No o_done is issued, the pointer is restored to N_REQ-1, and the requester must re-request.
- o_busy=1 in ISSUE and WAIT.

Test Plan:
- Single request:
  - Stimulus: i_req=0001; A=identity, B={1..9}; ready always high; LAT=2.
  - Required: o_gnt=0001 for one cycle; o_done=0001 exactly 2 cycles after trigger; o_result={1,2,3,4,5,6,7,8,9}.
- Round-robin fairness: i_req=1111 held through 8 operations -> grant order 0,1,2,3,0,1,2,3; one o_done per grant; no grant overlaps an in-flight operation.
- Ready stall: i_mm_ready low for 5 cycles after grant -> o_mm_trigger stays 0, state holds in ISSUE, o_busy=1; trigger fires on the first ready-high cycle; done follows LAT cycles later.
- Operand isolation:
  - Stimulus: requester 2 has A=all 2, B=all 3; change its A to 0 the cycle after grant.
  - Required: result elements all 18 (2*3*3=18, fits in 7 bits); o_done=0100.
- Truncation pass-through: A=all 10, B=all 10 -> engine result per element 300 mod 128 = 44; o_result elements all 44.
- Reset mid-WAIT:
  - Stimulus: assert i_rst one cycle into WAIT.
  - Required: all outputs 0 asynchronously, no o_done. After release with i_req=1010, requester 1 is granted first (pointer reset).
